fs_energy_sequencer: RTL and testbench
======================================

// Module: fs_energy_sequencer
// PURPOSE
//   Time-multiplexes one fast_square instance across a block of NUM_SAMP signed error samples.
//   Produces their sum of squares (energy), the largest square and the index of that largest square.
//   Sits after the error slicer and feeds the channel-estimate / MLSD energy-check logic.
//   Replaces NUM_SAMP parallel squarers with one registered squarer plus an accumulator.
// PARAMETERS
//   NUM_SAMP   16                          samples per block; >=2
//   IDX_W      $clog2(NUM_SAMP)            width of sample index
//   ACC_W      SQ_W+$clog2(NUM_SAMP)       energy accumulator width; never overflows
// PORTS
//   clk        in   1                      single clock, rising edge
//   rst        in   1                      synchronous, active-high reset
//   start      in   1                      request a block computation; accepted only in IDLE
//   samples    in   NUM_SAMP x SAMP_W      signed two's-complement samples; sampled on the accepted start edge
//   busy       out  1                      high whenever state != IDLE
//   done       out  1                      one-cycle pulse; energy, peak_sq and peak_idx are valid from this cycle
//   energy     out  ACC_W                  sum of squares of the block, unsigned
//   peak_sq    out  SQ_W                   largest single square in the block
//   peak_idx   out  IDX_W                  index of the first sample with the largest square
// BEHAVIOUR
//   - Reset: state=IDLE; busy=0, done=0, energy=0, peak_sq=0, peak_idx=0; internal idx, acc and sq_vld cleared.
//   - IDLE: start=1 at edge t latches samples into buf, clears acc/max/sq_vld, sets idx=0, state->SQUARE.
//   - SQUARE, every cycle:
//       sq_reg <= fast_square(buf[idx]); sq_vld <= 1; sq_idx <= idx.
//       If sq_vld: acc += sq_reg, and the peak update below is applied.
//       When idx==NUM_SAMP-1: state->DRAIN; otherwise idx++.
//   - Peak update: if sq_reg > max_sq (strict), max_sq <= sq_reg and max_idx <= sq_idx. Ties keep the lower index.
//   - DRAIN: the last sq_reg is folded into acc and the peak; state->DONE.
//   - DONE:
//       energy/peak_sq/peak_idx <= final values. Because these are registered outputs, they become visible
//         on the cycle after DONE, which is the same cycle done is high.
//       done is registered and is high for exactly that one cycle (the cycle after DONE).
//       state->IDLE.
//   - Timing: start accepted at edge t -> done=1 and outputs valid in the cycle after edge t+NUM_SAMP+2.
//       busy is high from the cycle after edge t through the cycle after edge t+NUM_SAMP+1.
//       Throughput is one block per NUM_SAMP+3 cycles.
//       Next start is accepted at the earliest on the cycle in which done is high, since the FSM is back in IDLE.
//   - start while busy: ignored, with no queueing. samples changing while busy has no effect (buf holds the block).
//   - Outputs energy/peak_sq/peak_idx hold their last values until the next done; they are never cleared except by rst.
//   - rst mid-block: immediate return to IDLE; the partial result is discarded; done is not asserted; outputs go to 0.
//   - Width rules:
//       square is unsigned SQ_W; (-256)^2 = 65536 must be exact.
//       acc is zero-extended to ACC_W; it never wraps, since the maximum is NUM_SAMP*65536.
// STRUCTURE
//   - Shared package fs_pkg: SAMP_W=9, SQ_W=18, and typedef enum logic [1:0] {IDLE,SQUARE,DRAIN,DONE} fs_seq_state_t.
//   - One sub-module: the existing fast_square (a -> sqr_a), instantiated once and combinational.
//     Its output is registered in this block.
//   - Everything else is a flat FSM plus index counter, accumulator and peak tracker in this file.
// TESTING (NUM_SAMP=16)
//   1. All samples 0, start -> done exactly 18 cycles after the start edge; energy=0, peak_sq=0, peak_idx=0.
//   2. All samples -256 -> energy=1048576, peak_sq=65536, peak_idx=0 (tie keeps lowest index).
//   3. samples[i]=i (0..15) -> energy=1240, peak_sq=225, peak_idx=15.
//   4. samples[i]=(-1)^i*3; samples[9]=-100 -> energy=15*9+10000=10135, peak_sq=10000, peak_idx=9.
//   5. Block A active; pulse start and change samples mid-block -> single done, result of A only.
//      Then start in the done cycle -> second block accepted, done 18 cycles later.
//   6. rst asserted 5 cycles into a block -> busy=0 and all outputs 0 the next cycle, no done pulse.
//      A fresh start then produces correct results.
//   - Scoreboard: reference model of sum/max over random 9-bit signed blocks, 1000 blocks, compared on every done.

Source files
------------

// File: rtl/fs_pkg.sv
// Shared types and constants for the energy sequencer and its squarer.
package fs_pkg;

  localparam int SAMP_W = 9;
  localparam int SQ_W   = 18;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQUARE = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } fs_seq_state_t;

  // Magnitude of a two's-complement sample, returned as unsigned of the same
  // width. The most negative code (-256) maps to 256, which still fits
  // because the result is read as unsigned.
  function automatic logic [SAMP_W-1:0] abs_mag(input logic [SAMP_W-1:0] a);
    logic [SAMP_W-1:0] mag;
    if (a[SAMP_W-1]) begin
      mag = ~a + {{(SAMP_W-1){1'b0}}, 1'b1};
    end else begin
      mag = a;
    end
    return mag;
  endfunction

endpackage

// File: rtl/fast_square.sv
// Combinational square of a signed sample. Result is unsigned and exact for
// every input, including (-256)^2 = 65536.
module fast_square
  import fs_pkg::*;
(
  input  logic [SAMP_W-1:0] a,
  output logic [SQ_W-1:0]   sqr_a
);

  logic [SAMP_W-1:0] mag_s;

  // Square the magnitude; the product of two 9-bit magnitudes fits in SQ_W.
  always_comb begin
    mag_s = abs_mag(a);
    sqr_a = SQ_W'(mag_s) * SQ_W'(mag_s);
  end

endmodule

// File: rtl/fs_energy_sequencer.sv
// Block energy sequencer: walks one squarer across NUM_SAMP buffered samples,
// accumulating the sum of squares and tracking the largest square and the
// index of its first occurrence.
module fs_energy_sequencer
  import fs_pkg::*;
#(
  parameter int NUM_SAMP = 16,
  parameter int IDX_W    = $clog2(NUM_SAMP),
  parameter int ACC_W    = SQ_W + $clog2(NUM_SAMP)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NUM_SAMP*SAMP_W-1:0] samples,
  output logic                       busy,
  output logic                       done,
  output logic [ACC_W-1:0]           energy,
  output logic [SQ_W-1:0]            peak_sq,
  output logic [IDX_W-1:0]           peak_idx
);

  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SAMP - 1);

  fs_seq_state_t     state_r;
  logic [SAMP_W-1:0] samp_buf_r [NUM_SAMP];
  logic [IDX_W-1:0]  idx_r;
  logic [SQ_W-1:0]   sq_r;
  logic              sq_vld_r;
  logic [IDX_W-1:0]  sq_idx_r;
  logic [ACC_W-1:0]  acc_r;
  logic [SQ_W-1:0]   max_sq_r;
  logic [IDX_W-1:0]  max_idx_r;

  logic              busy_r;
  logic              done_r;
  logic [ACC_W-1:0]  energy_r;
  logic [SQ_W-1:0]   peak_sq_r;
  logic [IDX_W-1:0]  peak_idx_r;

  logic [SAMP_W-1:0] cur_samp_s;
  logic [SQ_W-1:0]   sq_s;
  logic [ACC_W-1:0]  acc_fold_s;
  logic              peak_upd_s;

  // Select the buffered sample currently being squared.
  always_comb begin
    cur_samp_s = samp_buf_r[idx_r];
  end

  fast_square u_fast_square (
    .a     (cur_samp_s),
    .sqr_a (sq_s)
  );

  // Fold candidates for the pending registered square: accumulator sum and a
  // strict-greater peak test so ties keep the earlier index.
  always_comb begin
    acc_fold_s = acc_r + ACC_W'(sq_r);
    if (sq_r > max_sq_r) begin
      peak_upd_s = 1'b1;
    end else begin
      peak_upd_s = 1'b0;
    end
  end

  // Sequencer FSM with index counter, squarer pipeline register, accumulator,
  // peak tracker and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      idx_r      <= '0;
      sq_r       <= '0;
      sq_vld_r   <= 1'b0;
      sq_idx_r   <= '0;
      acc_r      <= '0;
      max_sq_r   <= '0;
      max_idx_r  <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      energy_r   <= '0;
      peak_sq_r  <= '0;
      peak_idx_r <= '0;
      for (int i = 0; i < NUM_SAMP; i++) begin
        samp_buf_r[i] <= '0;
      end
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_SAMP; i++) begin
              samp_buf_r[i] <= samples[i*SAMP_W +: SAMP_W];
            end
            idx_r     <= '0;
            sq_vld_r  <= 1'b0;
            acc_r     <= '0;
            max_sq_r  <= '0;
            max_idx_r <= '0;
            busy_r    <= 1'b1;
            state_r   <= SQUARE;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end

        SQUARE: begin
          sq_r     <= sq_s;
          sq_vld_r <= 1'b1;
          sq_idx_r <= idx_r;
          if (sq_vld_r) begin
            acc_r <= acc_fold_s;
            if (peak_upd_s) begin
              max_sq_r  <= sq_r;
              max_idx_r <= sq_idx_r;
            end
          end
          if (idx_r == IDX_LAST) begin
            state_r <= DRAIN;
          end else begin
            idx_r <= idx_r + IDX_ONE;
          end
        end

        DRAIN: begin
          // The last square leaves the pipeline register here.
          if (sq_vld_r) begin
            acc_r <= acc_fold_s;
            if (peak_upd_s) begin
              max_sq_r  <= sq_r;
              max_idx_r <= sq_idx_r;
            end
          end
          sq_vld_r <= 1'b0;
          state_r  <= DONE;
        end

        DONE: begin
          energy_r   <= acc_r;
          peak_sq_r  <= max_sq_r;
          peak_idx_r <= max_idx_r;
          done_r     <= 1'b1;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end

        default: begin
          busy_r   <= 1'b0;
          sq_vld_r <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign energy   = energy_r;
  assign peak_sq  = peak_sq_r;
  assign peak_idx = peak_idx_r;

endmodule

// File: tb/tb_fs_energy_sequencer.sv
// Scoreboard bench for fs_energy_sequencer (NUM_SAMP=16): directed blocks
// with hand-computed results plus random blocks checked against a sum/max
// reference model. A monitor pops expectations on every done pulse.
module tb_fs_energy_sequencer;

  localparam int NS    = 16;
  localparam int W     = 9;
  localparam int ACC_W = 22;
  localparam int SQ_W  = 18;
  localparam int IDX_W = 4;
  localparam int LAT   = NS + 3;  // negedges from accept edge to done cycle

  typedef struct packed {
    logic [ACC_W-1:0] energy;
    logic [SQ_W-1:0]  peak_sq;
    logic [IDX_W-1:0] peak_idx;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              start;
  logic [NS*W-1:0]   samples;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  energy;
  logic [SQ_W-1:0]   peak_sq;
  logic [IDX_W-1:0]  peak_idx;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  fs_energy_sequencer #(.NUM_SAMP(NS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .samples  (samples),
    .busy     (busy),
    .done     (done),
    .energy   (energy),
    .peak_sq  (peak_sq),
    .peak_idx (peak_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input int e, input int p, input int i);
    exp_t r;
    r.energy   = ACC_W'(e);
    r.peak_sq  = SQ_W'(p);
    r.peak_idx = IDX_W'(i);
    return r;
  endfunction

  function automatic exp_t ref_model(input logic [NS*W-1:0] blk);
    exp_t r;
    int   s;
    int   sq;
    int   acc;
    int   mx;
    int   mi;
    acc = 0; mx = 0; mi = 0;
    for (int i = 0; i < NS; i++) begin
      s  = $signed(blk[i*W +: W]);
      sq = s * s;
      acc += sq;
      if (sq > mx) begin
        mx = sq;
        mi = i;
      end
    end
    r = mk_exp(acc, mx, mi);
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1, expected no done");
      end else begin
        exp_t e;
        e = q.pop_front();
        check("energy",   32'(energy),   32'(e.energy));
        check("peak_sq",  32'(peak_sq),  32'(e.peak_sq));
        check("peak_idx", 32'(peak_idx), 32'(e.peak_idx));
      end
    end
  end

  // Called at a negedge: present a block, let the next edge accept it.
  task automatic start_block(input logic [NS*W-1:0] blk, input exp_t e);
    samples = blk;
    start   = 1'b1;
    @(posedge clk);
    q.push_back(e);
    #1 start = 1'b0;
  endtask

  // Wait (bounded) for done; returns at the negedge of the done cycle.
  task automatic wait_done(input string name, input int exp_n);
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    check(name, 32'(n), 32'(exp_n));
    if (!done) q.delete();
  endtask

  logic [NS*W-1:0] blk;
  logic [NS*W-1:0] blk_b;

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    samples = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_energy",   32'(energy),   32'd0);
    check("rst_peak_sq",  32'(peak_sq),  32'd0);
    check("rst_peak_idx", 32'(peak_idx), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: all zeros, with latency and busy window checks
    blk = '0;
    start_block(blk, mk_exp(0, 0, 0));
    @(negedge clk);
    check("busy_after_accept", 32'(busy), 32'd1);
    wait_done("latency_zero", LAT - 1);
    check("busy_in_done", 32'(busy), 32'd0);

    // 2: all -256, tie keeps lowest index
    for (int i = 0; i < NS; i++) blk[i*W +: W] = 9'h100;
    start_block(blk, mk_exp(1048576, 65536, 0));
    wait_done("latency_neg256", LAT);

    // 3: ramp 0..15, then outputs must hold afterwards
    for (int i = 0; i < NS; i++) blk[i*W +: W] = W'(i);
    start_block(blk, mk_exp(1240, 225, 15));
    wait_done("latency_ramp", LAT);
    repeat (3) @(negedge clk);
    check("hold_energy",   32'(energy),   32'd1240);
    check("hold_peak_idx", 32'(peak_idx), 32'd15);

    // 4: alternating +/-3 with a -100 spike at index 9
    for (int i = 0; i < NS; i++) blk[i*W +: W] = (i % 2 == 0) ? 9'd3 : 9'h1FD;
    blk[9*W +: W] = 9'h19C;
    start_block(blk, mk_exp(10135, 10000, 9));
    wait_done("latency_spike", LAT);

    // 5: start + sample change mid-block ignored; restart in the done cycle
    for (int i = 0; i < NS; i++) blk[i*W +: W] = 9'd5;
    for (int i = 0; i < NS; i++) blk_b[i*W +: W] = 9'h100;
    start_block(blk, mk_exp(400, 25, 0));
    repeat (4) @(negedge clk);
    samples = blk_b;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("latency_busy_start", LAT - 5);
    for (int i = 0; i < NS; i++) blk[i*W +: W] = W'(NS - 1 - i);
    start_block(blk, mk_exp(1240, 225, 0));
    wait_done("latency_back_to_back", LAT);

    // 6: reset 5 cycles into a block
    for (int i = 0; i < NS; i++) blk[i*W +: W] = 9'd7;
    start_block(blk, mk_exp(784, 49, 0));
    repeat (5) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    check("midrst_busy",     32'(busy),     32'd0);
    check("midrst_done",     32'(done),     32'd0);
    check("midrst_energy",   32'(energy),   32'd0);
    check("midrst_peak_sq",  32'(peak_sq),  32'd0);
    check("midrst_peak_idx", 32'(peak_idx), 32'd0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    for (int i = 0; i < NS; i++) blk[i*W +: W] = W'(i);
    start_block(blk, mk_exp(1240, 225, 15));
    wait_done("latency_after_rst", LAT);

    // Random blocks against the reference model
    for (int b = 0; b < 1000; b++) begin
      for (int i = 0; i < NS; i++) blk[i*W +: W] = W'($urandom_range(0, 511));
      start_block(blk, ref_model(blk));
      wait_done("latency_random", LAT);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
